max_change_logger: RTL and testbench

Downstream consumer of the running-maximum tracker's 2-bit output stream. It watches the tracker's `y` value every clock, detects each change, and tags each change with a free-running cycle timestamp. Each tagged event is queued in a small FIFO and handed to a debug or status reader over a valid/ready handshake. The block lets software or a testbench read back when the tracked maximum changed and what it changed to, without sampling every cycle.

---
 rtl/max_change_logger.sv | 102 ++++++++++
 tb/tb_max_change_logger.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/max_change_logger.sv
// rtl/max_change_logger.sv - timestamped change logger for a 2-bit running-maximum stream
module max_change_logger #(
   parameter int TS_W  = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                max_in,
   input  logic                      ovf_clr,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [TS_W+1:0]           evt_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = TS_W + 2;

   logic [TS_W-1:0] ts_q, ts_d;
   logic [1:0]      prev_q, prev_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];

   logic push, pop, full, wr_en, drop;

   // Change detection, FIFO control and next-state computation.
   always_comb begin
      push       = (max_in != prev_q);
      pop        = (count_q != '0) && evt_ready;
      full       = (count_q == CW'(DEPTH));
      // When full, a same-edge pop frees the head slot, which is exactly where wr_ptr points.
      wr_en      = push && (!full || pop);
      drop       = push && full && !pop;

      ts_d       = ts_q + TS_W'(1);
      prev_d     = max_in;
      wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d    = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A drop on the same edge as a clear keeps the flag set.
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end

      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_en) begin
         mem_d[wr_ptr_q] = {max_in, ts_q};
      end
   end

   // State registers; storage is cleared too so evt_data reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q       <= '0;
         prev_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ts_q       <= ts_d;
         prev_q     <= prev_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Outputs are registers or a register mux; nothing combinational from the inputs.
   always_comb begin
      evt_valid = (count_q != '0);
      evt_data  = mem_q[rd_ptr_q];
      count     = count_q;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_max_change_logger.sv
// tb/tb_max_change_logger.sv - scoreboard bench for max_change_logger
module tb_max_change_logger;

   localparam int TS_W  = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       max_in = 2'd0;
   logic             ovf_clr = 1'b0;
   logic             evt_valid;
   logic             evt_ready = 1'b0;
   logic [TS_W+1:0]  evt_data;
   logic [2:0]       count;
   logic             overflow;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a queue of accepted events plus the sticky flag.
   logic [TS_W+1:0]  exp_q[$];
   logic [1:0]       m_prev = 2'd0;
   logic [TS_W-1:0]  m_ts = '0;
   logic             m_ovf = 1'b0;
   logic             pend_pop = 1'b0;

   max_change_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .max_in    (max_in),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_data  (evt_data),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model update on each clock edge, cleared by reset at any time.
   initial forever begin
      logic pop_now, chg, drop;
      int   pre;
      @(posedge clk or negedge rst);
      if (!rst) begin
         exp_q.delete();
         m_prev   = 2'd0;
         m_ts     = '0;
         m_ovf    = 1'b0;
         pend_pop = 1'b0;
      end else begin
         pop_now  = pend_pop;
         pend_pop = 1'b0;
         pre      = exp_q.size() + (pop_now ? 1 : 0);
         chg      = (max_in != m_prev);
         drop     = 1'b0;
         if (chg) begin
            if (pre < DEPTH || pop_now) exp_q.push_back({max_in, m_ts});
            else drop = 1'b1;
         end
         if (drop) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         m_prev = max_in;
         m_ts   = m_ts + 1'b1;
      end
   end

   // Monitor: mid-cycle status checks and pop-and-compare on each handshake.
   initial forever begin
      logic [TS_W+1:0] e;
      @(negedge clk);
      chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (exp_q.size() != 0 && evt_ready) begin
         e = exp_q.pop_front();
         chk("evt_data", 32'(evt_data), 32'(e));
         pend_pop = 1'b1;
      end
   end

   // Waits for an edge, then sets the inputs sampled by the following edge.
   task automatic step(input logic [1:0] mi, input logic rdy, input logic clr);
      @(posedge clk);
      #2;
      max_in = mi;
      evt_ready = rdy;
      ovf_clr = clr;
   endtask

   // Asserts reset for two edges; the inputs left behind feed edge 1 after release.
   task automatic do_reset();
      #1;
      rst = 1'b0;
      max_in = 2'd0;
      evt_ready = 1'b0;
      ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      logic [1:0] seq_up [6];
      logic [1:0] r;

      // Reset state.
      #3;
      chk("reset_valid", 32'(evt_valid), 0);
      chk("reset_count", 32'(count), 0);
      chk("reset_ovf", 32'(overflow), 0);
      chk("reset_data", 32'(evt_data), 0);

      // Reset and first event: change on edge 4 carries ts 3.
      do_reset();
      step(2'd0, 1'b0, 1'b0);
      step(2'd0, 1'b0, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("first_evt_data", 32'(evt_data), 32'h103);
      chk("first_evt_count", 32'(count), 1);
      chk("first_evt_ovf", 32'(overflow), 0);

      // Upstream-style rising sequence drained as it arrives.
      do_reset();
      seq_up = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
      foreach (seq_up[i]) begin
         step(seq_up[i], 1'b1, 1'b0);
         if (i > 0) chk("upstream_count_le1", 32'(count <= 3'd1), 1);
      end
      repeat (3) step(2'd3, 1'b1, 1'b0);

      // Overflow: six changes with no reader.
      do_reset();
      for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("ovf_count", 32'(count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_head", 32'(evt_data), 32'h101);
      step(2'd0, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("ovf_cleared", 32'(overflow), 0);
      step(2'd0, 1'b0, 1'b0);

      // Full with simultaneous push and pop, then drain in order.
      step(2'd1, 1'b1, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("full_pp_count", 32'(count), 4);
      chk("full_pp_ovf", 32'(overflow), 0);
      repeat (4) step(2'd1, 1'b1, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("drained_count", 32'(count), 0);

      // Timestamp wrap: changes on edges 256 and 257 carry ts 255 and 0.
      do_reset();
      repeat (254) step(2'd0, 1'b1, 1'b0);
      step(2'd1, 1'b1, 1'b0);
      step(2'd2, 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap_ts255", 32'(evt_data), 32'h1ff);
      @(negedge clk);
      chk("wrap_ts0", 32'(evt_data), 32'h200);
      step(2'd2, 1'b1, 1'b0);
      step(2'd2, 1'b1, 1'b0);

      // Randomised traffic with reader phases of varying eagerness.
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : max_in;
         if ((i / 100) % 2 == 0) step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
         else step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      repeat (DEPTH + 2) step(max_in, 1'b1, 1'b0);

      // Reset mid-operation with three entries queued and overflow set.
      do_reset();
      for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
      step(2'd1, 1'b1, 1'b0);
      step(2'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("pre_rst_count", 32'(count), 3);
      chk("pre_rst_ovf", 32'(overflow), 1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      max_in = 2'd0;
      #1;
      chk("async_rst_valid", 32'(evt_valid), 0);
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_ovf", 32'(overflow), 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (4) begin
         step(2'd0, 1'b1, 1'b0);
         @(negedge clk);
         chk("no_stale_valid", 32'(evt_valid), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
